// File: rtl/spi_tx_pkg.sv
// spi_tx_pkg: shared state type and frame constants for the CIPO path.
// Define SPI_TX_PARITY_EN to append an odd-parity bit to every frame.
package spi_tx_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SHIFT,
    NEXT
  } tx_state_t;

`ifdef SPI_TX_PARITY_EN
  localparam int FRAME_LEN = 9;
`else
  localparam int FRAME_LEN = 8;
`endif

  localparam int         CNT_W         = 4;
  localparam logic [7:0] IDLE_BYTE_DEF = 8'hA5;

  function automatic logic [FRAME_LEN-1:0] frame_bits(
    input logic [7:0] b
  );
`ifdef SPI_TX_PARITY_EN
    return {b, ~^b};
`else
    return b;
`endif
  endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// spi_sync_edge: N-flop synchronizer plus a delayed copy of the
// synchronized level, giving one-cycle rise/fall pulses in clk.
module spi_sync_edge #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= {STAGES{RST_VAL}};
      prev_q <= RST_VAL;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d};
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign rise = sync_q[STAGES-1] & ~prev_q;
  assign fall = ~sync_q[STAGES-1] & prev_q;

endmodule

// File: rtl/spi_cipo_transmitter.sv
// spi_cipo_transmitter: SPI mode-0 CIPO shifter, clk-domain only.
// Optional odd parity bit per frame via SPI_TX_PARITY_EN.
module spi_cipo_transmitter
  import spi_tx_pkg::*;
#(
  parameter logic [7:0] IDLE_BYTE   = IDLE_BYTE_DEF,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       SCLK,
  input  logic       spi_cs_n,
  output logic       CIPO,
  output logic       cipo_oe,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       byte_sent,
  output logic       tx_underrun,
  output logic       tx_abort,
  output logic       busy
);

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(FRAME_LEN);

  tx_state_t            state_q, state_d;
  logic [FRAME_LEN-1:0] shift_q, shift_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [7:0]           hold_q, hold_d;
  logic                 full_q, full_d;
  logic                 sent_q, sent_d;
  logic                 under_q, under_d;
  logic                 abort_q, abort_d;
  logic                 sclk_rise, sclk_fall;
  logic                 cs_rise, cs_fall;
  logic                 accept;

  spi_sync_edge #(
    .STAGES  (SYNC_STAGES),
    .RST_VAL (1'b0)
  ) u_sclk (
    .clk  (clk),
    .rst  (rst),
    .d    (SCLK),
    .rise (sclk_rise),
    .fall (sclk_fall)
  );

  spi_sync_edge #(
    .STAGES  (SYNC_STAGES),
    .RST_VAL (1'b1)
  ) u_cs (
    .clk  (clk),
    .rst  (rst),
    .d    (spi_cs_n),
    .rise (cs_rise),
    .fall (cs_fall)
  );

  assign accept = tx_valid & ~full_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      shift_q <= '0;
      cnt_q   <= '0;
      hold_q  <= '0;
      full_q  <= 1'b0;
      sent_q  <= 1'b0;
      under_q <= 1'b0;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      hold_q  <= hold_d;
      full_q  <= full_d;
      sent_q  <= sent_d;
      under_q <= under_d;
      abort_q <= abort_d;
    end
  end

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    hold_d  = hold_q;
    full_d  = full_q;
    sent_d  = 1'b0;
    under_d = 1'b0;
    abort_d = 1'b0;
    if (accept) begin
      hold_d = tx_data;
      full_d = 1'b1;
    end
    // Deselect wins over any SCLK edge seen in the same cycle.
    if (cs_rise && state_q != IDLE) begin
      state_d = IDLE;
      shift_d = '0;
      cnt_d   = '0;
      abort_d = (state_q == LOAD) || (state_q == SHIFT);
    end else begin
      unique case (state_q)
        IDLE: begin
          if (cs_fall) state_d = LOAD;
        end
        LOAD: begin
          if (full_q) begin
            shift_d = frame_bits(hold_q);
            full_d  = 1'b0;
          end else begin
            shift_d = frame_bits(IDLE_BYTE);
            under_d = 1'b1;
          end
          cnt_d   = '0;
          state_d = SHIFT;
        end
        SHIFT: begin
          if (sclk_rise) begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_d == LAST_BIT) begin
              sent_d  = 1'b1;
              state_d = NEXT;
            end
          end else if (sclk_fall && cnt_q < LAST_BIT) begin
            shift_d = {shift_q[FRAME_LEN-2:0], 1'b0};
          end
        end
        NEXT: begin
          if (sclk_fall) state_d = LOAD;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign CIPO        = shift_q[FRAME_LEN-1];
  assign cipo_oe     = (state_q != IDLE);
  assign busy        = cipo_oe;
  assign tx_ready    = ~full_q;
  assign byte_sent   = sent_q;
  assign tx_underrun = under_q;
  assign tx_abort    = abort_q;

endmodule

// File: tb/tb_spi_cipo_transmitter.sv
// tb_spi_cipo_transmitter: table vectors, corner sequences and
// randomized CS transactions checked against a byte-level model.
module tb_spi_cipo_transmitter;

`ifdef SPI_TX_PARITY_EN
  localparam int FL = 9;
`else
  localparam int FL = 8;
`endif
  localparam int         HALF   = 8;
  localparam logic [7:0] IDLE_B = 8'hA5;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       SCLK = 1'b0;
  logic       spi_cs_n = 1'b1;
  logic       CIPO;
  logic       cipo_oe;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic       byte_sent;
  logic       tx_underrun;
  logic       tx_abort;
  logic       busy;

  int checks = 0;
  int errors = 0;
  int n_sent = 0;
  int n_under = 0;
  int n_abort = 0;

  bit         feed_en_a [3];
  logic [7:0] feed_d_a  [3];
  logic [8:0] rx_a      [3];

  typedef struct {
    bit         load;
    logic [7:0] data;
    logic [7:0] exp;
    bit         under;
  } vec_t;

  vec_t vec [6];

  spi_cipo_transmitter dut (
    .clk         (clk),
    .rst         (rst),
    .SCLK        (SCLK),
    .spi_cs_n    (spi_cs_n),
    .CIPO        (CIPO),
    .cipo_oe     (cipo_oe),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .byte_sent   (byte_sent),
    .tx_underrun (tx_underrun),
    .tx_abort    (tx_abort),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (byte_sent)   n_sent  <= n_sent + 1;
    if (tx_underrun) n_under <= n_under + 1;
    if (tx_abort)    n_abort <= n_abort + 1;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  function automatic logic [8:0] exp_frame(input logic [7:0] b);
    logic par;
    par = (($countones(b) % 2) == 0);
    return (FL == 9) ? {b, par} : {1'b0, b};
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic offer(input logic [7:0] d);
    int n;
    n = 0;
    tx_data  = d;
    tx_valid = 1'b1;
    while (!tx_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("offer_ready", tx_ready, 1);
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_cipo"}, CIPO, 0);
    chk({tag, "_oe"}, cipo_oe, 0);
    chk({tag, "_ready"}, tx_ready, 1);
    chk({tag, "_sent"}, byte_sent, 0);
    chk({tag, "_under"}, tx_underrun, 0);
    chk({tag, "_abort"}, tx_abort, 0);
    chk({tag, "_busy"}, busy, 0);
  endtask

  // Host side of one CS assertion carrying nb frames. The last SCLK
  // fall coincides with CS rise so no trailing frame is started.
  task automatic run_cs(input int nb);
    @(negedge clk);
    spi_cs_n = 1'b0;
    wait_clk(HALF);
    for (int k = 0; k < nb; k++) begin
      rx_a[k] = '0;
      for (int b = 0; b < FL; b++) begin
        rx_a[k] = {rx_a[k][7:0], CIPO};
        SCLK = 1'b1;
        if (b == 0 && feed_en_a[k]) begin
          offer(feed_d_a[k]);
          wait_clk(HALF - 1);
        end else begin
          wait_clk(HALF);
        end
        SCLK = 1'b0;
        if (k == nb - 1 && b == FL - 1) spi_cs_n = 1'b1;
        else wait_clk(HALF);
      end
    end
    wait_clk(HALF);
  endtask

  initial begin
    int s0, u0, a0, nb, eu;
    bit hv;
    logic [7:0] hd, ev;
    logic [2:0] ab_bits;

    vec[0] = '{1'b1, 8'h07, 8'h07, 1'b0};
    vec[1] = '{1'b0, 8'h00, 8'hA5, 1'b1};
    vec[2] = '{1'b1, 8'hFF, 8'hFF, 1'b0};
    vec[3] = '{1'b1, 8'h00, 8'h00, 1'b0};
    vec[4] = '{1'b1, 8'h01, 8'h01, 1'b0};
    vec[5] = '{1'b1, 8'h80, 8'h80, 1'b0};
    for (int k = 0; k < 3; k++) begin
      feed_en_a[k] = 1'b0;
      feed_d_a[k]  = 8'h00;
    end

    wait_clk(3);
    chk_reset_outputs("rst0");
    rst = 1'b0;
    wait_clk(4);

    for (int i = 0; i < 6; i++) begin
      s0 = n_sent; u0 = n_under; a0 = n_abort;
      if (vec[i].load) begin
        offer(vec[i].data);
        chk($sformatf("vec%0d_full", i), tx_ready, 0);
      end
      run_cs(1);
      wait_clk(4);
      chk($sformatf("vec%0d_rx", i), rx_a[0], exp_frame(vec[i].exp));
      chk($sformatf("vec%0d_sent", i), n_sent - s0, 1);
      chk($sformatf("vec%0d_under", i), n_under - u0, vec[i].under);
      chk($sformatf("vec%0d_abort", i), n_abort - a0, 0);
      chk($sformatf("vec%0d_ready", i), tx_ready, 1);
      chk($sformatf("vec%0d_oe", i), cipo_oe, 0);
    end

    // Back-to-back frames, second byte supplied during the first.
    s0 = n_sent; u0 = n_under; a0 = n_abort;
    offer(8'h3C);
    feed_en_a[0] = 1'b1;
    feed_d_a[0]  = 8'hC3;
    run_cs(2);
    feed_en_a[0] = 1'b0;
    wait_clk(4);
    chk("b2b_rx0", rx_a[0], exp_frame(8'h3C));
    chk("b2b_rx1", rx_a[1], exp_frame(8'hC3));
    chk("b2b_sent", n_sent - s0, 2);
    chk("b2b_under", n_under - u0, 0);
    chk("b2b_abort", n_abort - a0, 0);

    // Abort after three SCLK cycles of 8'hFF.
    s0 = n_sent; u0 = n_under; a0 = n_abort;
    offer(8'hFF);
    spi_cs_n = 1'b0;
    wait_clk(HALF);
    for (int b = 0; b < 3; b++) begin
      ab_bits[2-b] = CIPO;
      SCLK = 1'b1;
      wait_clk(HALF);
      SCLK = 1'b0;
      wait_clk(HALF);
    end
    chk("abort_bits", ab_bits, 3'b111);
    chk("abort_oe_before", cipo_oe, 1);
    spi_cs_n = 1'b1;
    wait_clk(3);
    chk("abort_oe_after", cipo_oe, 0);
    chk("abort_cipo_after", CIPO, 0);
    wait_clk(4);
    chk("abort_pulse", n_abort - a0, 1);
    chk("abort_sent", n_sent - s0, 0);
    chk("abort_ready", tx_ready, 1);
    u0 = n_under;
    run_cs(1);
    wait_clk(4);
    chk("post_abort_rx", rx_a[0], exp_frame(IDLE_B));
    chk("post_abort_under", n_under - u0, 1);

    // Async reset in the middle of bit 5 with a byte waiting.
    offer(8'h96);
    spi_cs_n = 1'b0;
    wait_clk(HALF);
    for (int b = 0; b < 4; b++) begin
      SCLK = 1'b1;
      if (b == 1) begin
        offer(8'h69);
        wait_clk(HALF - 1);
      end else begin
        wait_clk(HALF);
      end
      SCLK = 1'b0;
      wait_clk(HALF);
    end
    SCLK = 1'b1;
    wait_clk(4);
    chk("mid_busy", busy, 1);
    chk("mid_full", tx_ready, 0);
    rst = 1'b1;
    #1;
    chk_reset_outputs("rst_mid");
    spi_cs_n = 1'b1;
    SCLK = 1'b0;
    wait_clk(3);
    rst = 1'b0;
    wait_clk(4);
    chk_reset_outputs("rel");
    s0 = n_sent; u0 = n_under;
    run_cs(1);
    wait_clk(4);
    chk("post_rst_rx", rx_a[0], exp_frame(IDLE_B));
    chk("post_rst_under", n_under - u0, 1);
    chk("post_rst_sent", n_sent - s0, 1);

    // Randomized CS transactions against a byte-level model.
    for (int it = 0; it < 30; it++) begin
      nb = $urandom_range(1, 3);
      hv = 1'b0;
      hd = 8'h00;
      if ($urandom_range(0, 1) == 1) begin
        hd = 8'($urandom);
        hv = 1'b1;
        offer(hd);
      end
      for (int k = 0; k < 3; k++) begin
        feed_en_a[k] = (k < nb - 1) && ($urandom_range(0, 1) == 1);
        feed_d_a[k]  = 8'($urandom);
      end
      s0 = n_sent; u0 = n_under; a0 = n_abort;
      run_cs(nb);
      wait_clk(4);
      eu = 0;
      for (int k = 0; k < nb; k++) begin
        ev = hv ? hd : IDLE_B;
        if (!hv) eu++;
        hv = 1'b0;
        if (feed_en_a[k]) begin
          hv = 1'b1;
          hd = feed_d_a[k];
        end
        chk($sformatf("rnd%0d_rx%0d", it, k), rx_a[k], exp_frame(ev));
      end
      chk($sformatf("rnd%0d_sent", it), n_sent - s0, nb);
      chk($sformatf("rnd%0d_under", it), n_under - u0, eu);
      chk($sformatf("rnd%0d_abort", it), n_abort - a0, 0);
      chk($sformatf("rnd%0d_ready", it), tx_ready, 1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
